// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: sync -> optional glitch filter -> Gray-step decode -> wrapping position.
// Define QUAD_GLITCH_FILTER_EN to compile in the per-channel glitch filter.
module quad_decoder_multi #(
    parameter int CHANNELS   = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           a,
    input  logic [CHANNELS-1:0]           b,
    input  logic [CHANNELS-1:0]           clr,
    input  logic [CHANNELS-1:0]           err_clr,
    output logic [2*CHANNELS-1:0]         dir,
    output logic [CHANNELS*CNT_WIDTH-1:0] pos,
    output logic [CHANNELS-1:0]           err
);

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int SETTLE = 3 + FILTER_LEN;
    localparam int FW     = $clog2(FILTER_LEN + 1);
`else
    localparam int SETTLE = 3;
`endif
    // Counter is sized for the filtered build so both builds share one layout.
    localparam int                SET_W      = $clog2(FILTER_LEN + 4);
    localparam logic [SET_W-1:0]  SETTLE_MAX = SET_W'(SETTLE);

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_CW,
        STEP_CCW,
        STEP_BAD
    } step_e;

    function automatic step_e decode_step(input logic [1:0] p, input logic [1:0] c);
        case ({p, c})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return STEP_CW;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return STEP_CCW;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: return STEP_BAD;
            default:                                return STEP_NONE;
        endcase
    endfunction

    logic [SET_W-1:0] settle_cnt;
    logic             settling;

    assign settling = (settle_cnt != SETTLE_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            settle_cnt <= '0;
        else if (settling)
            settle_cnt <= settle_cnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]           sync1;
        logic [1:0]           sync2;
        logic [1:0]           cur;
        logic [1:0]           prev;
        logic [1:0]           dir_q;
        logic [CNT_WIDTH-1:0] pos_q;
        logic                 err_q;
        step_e                step;

`ifdef QUAD_GLITCH_FILTER_EN
        logic [1:0]    acc;
        logic [FW-1:0] fcnt;

        // Accept a new value only after FILTER_LEN consecutive differing samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc  <= 2'b00;
                fcnt <= '0;
            end else if (sync2 == acc) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                acc  <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end

        assign cur = acc;
`else
        assign cur = sync2;
`endif

        assign step = decode_step(prev, cur);

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1 <= 2'b00;
                sync2 <= 2'b00;
                prev  <= 2'b00;
                dir_q <= 2'b00;
                pos_q <= '0;
                err_q <= 1'b0;
            end else begin
                sync1 <= {a[i], b[i]};
                sync2 <= sync1;
                prev  <= cur;
                if (settling) begin
                    dir_q <= 2'b00;
                end else begin
                    dir_q <= (step == STEP_CW)  ? 2'b01 :
                             (step == STEP_CCW) ? 2'b10 : 2'b00;
                    // Clear takes priority over a same-cycle step; dir still reports it.
                    if (clr[i])
                        pos_q <= '0;
                    else if (step == STEP_CW)
                        pos_q <= pos_q + 1'b1;
                    else if (step == STEP_CCW)
                        pos_q <= pos_q - 1'b1;
                    if (step == STEP_BAD)
                        err_q <= 1'b1;
                    else if (err_clr[i])
                        err_q <= 1'b0;
                end
            end
        end

        assign dir[2*i +: 2]               = dir_q;
        assign pos[i*CNT_WIDTH +: CNT_WIDTH] = pos_q;
        assign err[i]                      = err_q;
    end

endmodule
